// File: rtl/fetch_unit.sv
// fetch_unit: IF-stage PC generator with optional direct-mapped BTB.
// Define FETCH_BTB_EN to build the BTB; without it fetch is static not-taken.
//
// Ports:
//   clk, rst_n                 clock, async active-low reset
//   stall                      pipeline stall code (LOAD/BRANCH hold the PC)
//   redirect_valid/_pc         EX mispredict correction (highest priority)
//   upd_valid/_pc/_taken/_target  resolved-branch BTB update
//   imem_addr / imem_rdata     sync imem: rdata is the word at last cycle's addr
//   PC_if, inst_if, bp_if, BTB_target_if, valid_if  feed of the IF/ID register

`ifndef STALL_WIDTH
`define STALL_WIDTH 2
`endif
`ifndef STALL_LOAD
`define STALL_LOAD 1
`endif
`ifndef STALL_BRANCH
`define STALL_BRANCH 2
`endif

module fetch_unit #(
    parameter logic [31:0] RESET_PC    = 32'h0000_0000,
    parameter int          BTB_ENTRIES = 8
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic [`STALL_WIDTH-1:0] stall,
    input  logic                    redirect_valid,
    input  logic [31:0]             redirect_pc,
    input  logic                    upd_valid,
    input  logic [31:0]             upd_pc,
    input  logic                    upd_taken,
    input  logic [31:0]             upd_target,
    output logic [31:0]             imem_addr,
    input  logic [31:0]             imem_rdata,
    output logic [31:0]             PC_if,
    output logic [31:0]             inst_if,
    output logic                    bp_if,
    output logic [31:0]             BTB_target_if,
    output logic                    valid_if
);

    logic [31:0] pc_q, pc_d;
    logic        valid_q, valid_d;
    logic        hold;
    logic        bp;
    logic [31:0] bp_target;

`ifdef FETCH_BTB_EN
    localparam int IW = $clog2(BTB_ENTRIES);
    localparam int TW = 30 - IW;

    logic          btb_v_q   [BTB_ENTRIES];
    logic          btb_v_d   [BTB_ENTRIES];
    logic [TW-1:0] btb_tag_q [BTB_ENTRIES];
    logic [TW-1:0] btb_tag_d [BTB_ENTRIES];
    logic [31:0]   btb_tgt_q [BTB_ENTRIES];
    logic [31:0]   btb_tgt_d [BTB_ENTRIES];
    logic [1:0]    btb_ctr_q [BTB_ENTRIES];
    logic [1:0]    btb_ctr_d [BTB_ENTRIES];

    logic [IW-1:0] lk_idx, up_idx;
    logic [TW-1:0] lk_tag, up_tag;
    logic          lk_hit, up_hit;
    logic          unused_upd_lsb;

    assign lk_idx = pc_q[IW+1:2];
    assign lk_tag = pc_q[31:IW+2];
    assign up_idx = upd_pc[IW+1:2];
    assign up_tag = upd_pc[31:IW+2];
    assign unused_upd_lsb = ^upd_pc[1:0];

    // Lookup reads the registered entries, so a same-cycle update
    // to the same index is only seen on the following cycle.
    assign lk_hit    = btb_v_q[lk_idx] && (btb_tag_q[lk_idx] == lk_tag);
    assign bp        = lk_hit && btb_ctr_q[lk_idx][1];
    assign bp_target = btb_tgt_q[lk_idx];
    assign up_hit    = btb_v_q[up_idx] && (btb_tag_q[up_idx] == up_tag);

    always_comb begin
        btb_v_d   = btb_v_q;
        btb_tag_d = btb_tag_q;
        btb_tgt_d = btb_tgt_q;
        btb_ctr_d = btb_ctr_q;
        if (upd_valid) begin
            if (up_hit) begin
                if (upd_taken) begin
                    if (btb_ctr_q[up_idx] != 2'b11)
                        btb_ctr_d[up_idx] = btb_ctr_q[up_idx] + 2'd1;
                    btb_tgt_d[up_idx] = upd_target;
                end else if (btb_ctr_q[up_idx] != 2'b00) begin
                    btb_ctr_d[up_idx] = btb_ctr_q[up_idx] - 2'd1;
                end
            end else if (upd_taken) begin
                btb_v_d[up_idx]   = 1'b1;
                btb_tag_d[up_idx] = up_tag;
                btb_tgt_d[up_idx] = upd_target;
                btb_ctr_d[up_idx] = 2'b10;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < BTB_ENTRIES; i++) begin
                btb_v_q[i]   <= 1'b0;
                btb_tag_q[i] <= '0;
                btb_tgt_q[i] <= '0;
                btb_ctr_q[i] <= 2'b00;
            end
        end else begin
            btb_v_q   <= btb_v_d;
            btb_tag_q <= btb_tag_d;
            btb_tgt_q <= btb_tgt_d;
            btb_ctr_q <= btb_ctr_d;
        end
    end
`else
    localparam int unused_btb_entries = BTB_ENTRIES;
    logic unused_upd;

    assign unused_upd = ^{upd_valid, upd_pc, upd_taken, upd_target};
    assign bp         = 1'b0;
    assign bp_target  = 32'h0;
`endif

    // pc_d is the next fetch PC; it doubles as the imem address so the
    // returned word lines up with pc_q one cycle later.
    always_comb begin
        hold = (stall == `STALL_WIDTH'(`STALL_LOAD)) ||
               (stall == `STALL_WIDTH'(`STALL_BRANCH));
        if (redirect_valid)
            pc_d = redirect_pc;
        else if (hold)
            pc_d = pc_q;
        else if (bp)
            pc_d = bp_target;
        else
            pc_d = pc_q + 32'd4;
        valid_d = 1'b1;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pc_q    <= RESET_PC;
            valid_q <= 1'b0;
        end else begin
            pc_q    <= pc_d;
            valid_q <= valid_d;
        end
    end

    // While in reset the memory is pointed at RESET_PC so its word is
    // ready in the first cycle after release.
    assign imem_addr     = rst_n ? pc_d : RESET_PC;
    assign PC_if         = pc_q;
    assign inst_if       = imem_rdata;
    assign bp_if         = bp;
    assign BTB_target_if = bp ? bp_target : 32'h0;
    assign valid_if      = valid_q;

endmodule

// File: doc/fetch_unit.md
FETCH_UNIT -- requirements
Module: fetch_unit

Interface
REQ-001 SHALL have parameter RESET_PC, default 32'h0000_0000, meaning PC value loaded on reset.
REQ-002 SHALL have parameter BTB_ENTRIES, default 8, meaning number of direct-mapped BTB entries (power of two, 2..64).
REQ-003 SHALL have ports: clk input 1, the single clock; rst_n input 1, asynchronous active-low reset.
REQ-004 SHALL have port stall input `STALL_WIDTH, pipeline stall code.
REQ-005 SHALL have ports redirect_valid input 1 and redirect_pc input 32, EX-stage mispredict correction.
REQ-006 SHALL have ports upd_valid input 1, upd_pc input 32, upd_taken input 1 and upd_target input 32, resolved-branch BTB update.
REQ-007 SHALL have ports imem_addr output 32, synchronous instruction-memory address, and imem_rdata input 32, data for the previous cycle's imem_addr.
REQ-008 SHALL have outputs PC_if 32, inst_if 32, bp_if 1, BTB_target_if 32 and valid_if 1, the fetch-side feed of the IF/ID register.

Function
REQ-009 SHALL hold the current fetch PC in register pc_q; PC_if SHALL equal pc_q and inst_if SHALL equal imem_rdata.
REQ-010 SHALL drive imem_addr combinationally with pc_next, so imem_rdata aligns with pc_q one cycle later.
REQ-011 SHALL compute pc_next by priority: redirect_valid -> redirect_pc; else stall equal to `STALL_LOAD or `STALL_BRANCH -> pc_q; else bp_if -> BTB_target_if; else pc_q + 4, mod 2^32.
REQ-012 SHALL index the BTB with pc_q[log2(BTB_ENTRIES)+1:2] and compare the tag against the remaining upper PC bits; each entry SHALL hold valid, tag, target and a 2-bit saturating counter.
REQ-013 SHALL assert bp_if combinationally when the entry is valid, the tag matches and counter[1] is 1; BTB_target_if SHALL be the entry target when bp_if is 1, else 0.
REQ-014 SHALL apply an update on the clock edge when upd_valid is 1: on a tag hit, increment the counter if upd_taken and decrement it otherwise, saturating at 3 and 0, and write the target only if upd_taken.
REQ-015 SHALL, on an update miss with upd_taken, allocate the entry (valid=1, new tag, target=upd_target, counter=2'b10); an update miss without upd_taken SHALL leave the entry unchanged.
REQ-016 SHALL give the lookup the pre-update entry contents when the lookup and the update hit the same index in one cycle.
REQ-017 SHALL not let stall block a BTB update; redirect and update in the same cycle SHALL both take effect.
REQ-018 SHALL drive valid_if to 0 in the first cycle after rst_n deasserts and to 1 thereafter; redirect SHALL NOT clear it, because squashing is done downstream via flush.
REQ-019 SHALL keep pc_next, and therefore imem_addr, constant during stall, so that inst_if stays stable.

Reset
REQ-020 SHALL, while rst_n is 0 and asynchronously, set pc_q to RESET_PC, clear all BTB valid bits and counters, set valid_if to 0, and drive imem_addr to RESET_PC.
REQ-021 SHALL, on reset asserted mid-operation, discard any update in flight that cycle, with no partial BTB write.

Configuration
REQ-022 SHALL, with macro FETCH_BTB_EN defined, include the BTB and prediction as specified above.
REQ-023 SHALL, without FETCH_BTB_EN, omit the BTB storage, tie bp_if to 0 and BTB_target_if to 0, ignore the upd_* ports, and use a static not-taken pc_next.

Verification
REQ-024 SHALL test reset release with RESET_PC=0x100 and no stall -> PC_if sequence 0x100, 0x104, 0x108; valid_if is 0 then 1.
REQ-025 SHALL test stall=`STALL_LOAD for 3 cycles at PC 0x108 -> PC_if and inst_if are held at 0x108 and its word; after release the next PC_if is 0x10C.
REQ-026 SHALL test redirect_valid with redirect_pc=0x200 while stall=`STALL_BRANCH -> the next PC_if is 0x200, since redirect wins over stall.
REQ-027 SHALL test an update with upd_pc=0x10C, upd_taken=1, upd_target=0x300, then refetch of 0x10C -> bp_if=1, BTB_target_if=0x300, next PC_if 0x300.
REQ-028 SHALL test two not-taken updates on the 0x10C entry -> the counter goes 2->1->0, and refetch of 0x10C gives bp_if=0 and next PC 0x110.
REQ-029 SHALL test aliasing, with BTB_ENTRIES=8 and upd_pc 0x10C then lookup at 0x12C (same index, different tag) -> bp_if=0; a build without FETCH_BTB_EN -> bp_if is always 0.
